mips_cpu_state_sequencer: RTL and testbench

Multicycle state sequencer for the MIPS CPU core. It generates the 3-bit instruction phase (FETCH/DECODE/EXEC1/EXEC2) consumed by the decode/controller stage. It advances phases according to the controller's threecycle/memread/memwrite outputs and stalls on memory waitrequest or multiply/divide busy. It also handles the halt sequence (jump to address 0 plus delay slot), drives the CPU active flag, and keeps saturating cycle and retired-instruction counters.

---
 rtl/mips_cpu_state_sequencer.sv | 133 +++++++++++++
 tb/tb_mips_cpu_state_sequencer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mips_cpu_state_sequencer.sv
// Multicycle phase sequencer for the MIPS core: FETCH/DECODE/EXEC1/EXEC2
// sequencing with memory/muldiv stalls, halt handling and saturating counters.
module mips_cpu_state_sequencer #(
    parameter int unsigned COUNT_WIDTH           = 32,
    parameter bit          HALT_AFTER_DELAY_SLOT = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   waitrequest,
    input  logic                   memread,
    input  logic                   memwrite,
    input  logic                   threecycle,
    input  logic                   muldiv_busy,
    input  logic                   halt_req,
    output logic [2:0]             state,
    output logic                   active,
    output logic                   stall,
    output logic                   retire,
    output logic                   fault,
    output logic [COUNT_WIDTH-1:0] cycle_count,
    output logic [COUNT_WIDTH-1:0] instr_count
);

    localparam int unsigned STATE_W = 3;

    localparam logic [STATE_W-1:0] S_RESET  = 3'd0;
    localparam logic [STATE_W-1:0] S_FETCH  = 3'd1;
    localparam logic [STATE_W-1:0] S_DECODE = 3'd2;
    localparam logic [STATE_W-1:0] S_EXEC1  = 3'd3;
    localparam logic [STATE_W-1:0] S_EXEC2  = 3'd4;
    localparam logic [STATE_W-1:0] S_HALTED = 3'd5;

    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = {COUNT_WIDTH{1'b1}};

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    logic               halt_pending_q;
    logic               halt_pending_d;
    logic               halt_seen_q;     // halt_req seen in EXEC1 of a four-phase instruction
    logic               halt_seen_d;
    logic               fault_d;
    logic               active_d;
    logic               mem_stall;
    logic               halt_hit;

    assign mem_stall = (memread | memwrite) & waitrequest;
    assign halt_hit  = halt_req | halt_seen_q;
    assign state     = state_q;

    // State, halt tracking, fault and active flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_RESET;
            halt_pending_q <= 1'b0;
            halt_seen_q    <= 1'b0;
            fault          <= 1'b0;
            active         <= 1'b0;
        end else begin
            state_q        <= state_d;
            halt_pending_q <= halt_pending_d;
            halt_seen_q    <= halt_seen_d;
            fault          <= fault_d;
            active         <= active_d;
        end
    end

    // Next-state, stall/retire and halt decisions
    always_comb begin
        state_d        = state_q;
        halt_pending_d = halt_pending_q;
        halt_seen_d    = halt_seen_q;
        fault_d        = fault;
        stall          = 1'b0;
        retire         = 1'b0;

        case (state_q)
            S_RESET:  state_d = S_FETCH;
            S_FETCH: begin
                if (mem_stall) stall = 1'b1;
                else           state_d = S_DECODE;
            end
            S_DECODE: state_d = S_EXEC1;
            S_EXEC1: begin
                if (mem_stall || muldiv_busy) begin
                    stall = 1'b1;
                end else if (threecycle) begin
                    retire = 1'b1;
                end else begin
                    state_d = S_EXEC2;
                    if (halt_req) halt_seen_d = 1'b1;
                end
            end
            S_EXEC2: begin
                if (mem_stall) stall = 1'b1;
                else           retire = 1'b1;
            end
            S_HALTED: state_d = S_HALTED;
            default: begin
                state_d = S_HALTED;
                fault_d = 1'b1;
            end
        endcase

        // Completion: back to FETCH unless the halt sequence ends here
        if (retire) begin
            halt_seen_d = 1'b0;
            state_d     = S_FETCH;
            if (HALT_AFTER_DELAY_SLOT) begin
                if (halt_pending_q)  state_d = S_HALTED;
                else if (halt_hit)   halt_pending_d = 1'b1;
            end else if (halt_hit) begin
                state_d = S_HALTED;
            end
        end

        active_d = (state_d == S_FETCH) || (state_d == S_DECODE) ||
                   (state_d == S_EXEC1) || (state_d == S_EXEC2);
    end

    // Saturating cycle and retired-instruction counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_count <= '0;
            instr_count <= '0;
        end else begin
            if (active && (cycle_count != COUNT_MAX))
                cycle_count <= cycle_count + COUNT_WIDTH'(1);
            if (retire && (instr_count != COUNT_MAX))
                instr_count <= instr_count + COUNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_mips_cpu_state_sequencer.sv
// Directed bench: default, halt-immediately and 4-bit-counter variants in lockstep.
module tb_mips_cpu_state_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    logic waitrequest, memread, memwrite, threecycle, muldiv_busy, halt_req;

    logic [2:0]  s0, s1, s2;
    logic        a0, a1, a2, st0, st1, st2, r0, r1, r2, f0, f1, f2;
    logic [31:0] cc0, ic0, cc1, ic1;
    logic [3:0]  cc2, ic2;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mips_cpu_state_sequencer u0 (
        .clk(clk), .rst_n(rst_n), .waitrequest(waitrequest), .memread(memread),
        .memwrite(memwrite), .threecycle(threecycle), .muldiv_busy(muldiv_busy),
        .halt_req(halt_req), .state(s0), .active(a0), .stall(st0), .retire(r0),
        .fault(f0), .cycle_count(cc0), .instr_count(ic0)
    );

    mips_cpu_state_sequencer #(.HALT_AFTER_DELAY_SLOT(1'b0)) u1 (
        .clk(clk), .rst_n(rst_n), .waitrequest(waitrequest), .memread(memread),
        .memwrite(memwrite), .threecycle(threecycle), .muldiv_busy(muldiv_busy),
        .halt_req(halt_req), .state(s1), .active(a1), .stall(st1), .retire(r1),
        .fault(f1), .cycle_count(cc1), .instr_count(ic1)
    );

    mips_cpu_state_sequencer #(.COUNT_WIDTH(4)) u2 (
        .clk(clk), .rst_n(rst_n), .waitrequest(waitrequest), .memread(memread),
        .memwrite(memwrite), .threecycle(threecycle), .muldiv_busy(muldiv_busy),
        .halt_req(halt_req), .state(s2), .active(a2), .stall(st2), .retire(r2),
        .fault(f2), .cycle_count(cc2), .instr_count(ic2)
    );

    // Count one comparison and report it on mismatch
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Advance one rising edge and settle just after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int exp_pre[7]    = '{0, 1, 2, 3, 1, 2, 3};
    int exp_retire[7] = '{0, 0, 0, 1, 0, 0, 1};

    initial begin
        rst_n = 1'b0; waitrequest = 1'b0; memread = 1'b0; memwrite = 1'b0;
        threecycle = 1'b1; muldiv_busy = 1'b0; halt_req = 1'b0;
        step(); step();
        check("rst_state", 32'(s0), 0);
        check("rst_active", 32'(a0), 0);
        check("rst_stall", 32'(st0), 0);
        check("rst_retire", 32'(r0), 0);
        check("rst_fault", 32'(f0), 0);
        check("rst_cycles", cc0, 0);
        rst_n = 1'b1;
        #1;

        // Three-phase instructions: 0,1,2,3,1,2,3 with retire in EXEC1
        for (int k = 0; k < 7; k++) begin
            check("seq_state", 32'(s0), 32'(exp_pre[k]));
            check("seq_retire", 32'(r0), 32'(exp_retire[k]));
            check("seq_active", 32'(a0), (k == 0) ? 0 : 1);
            step();
        end
        check("seq_state_end", 32'(s0), 1);
        check("seq_cycles", cc0, 6);
        check("seq_instrs", ic0, 2);

        // Four-phase load with waitrequest held for three EXEC2 cycles
        threecycle = 1'b0; memread = 1'b1;
        step(); step(); step();
        check("ld_in_exec2", 32'(s0), 4);
        waitrequest = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("ld_stall", 32'(st0), 1);
            check("ld_noretire", 32'(r0), 0);
            step();
            check("ld_hold", 32'(s0), 4);
        end
        check("ld_instrs_held", ic0, 2);
        waitrequest = 1'b0;
        #1;
        check("ld_retire", 32'(r0), 1);
        check("ld_nostall", 32'(st0), 0);
        step();
        check("ld_fetch", 32'(s0), 1);
        check("ld_instrs", ic0, 3);
        check("ld_cycles", cc0, 13);

        // muldiv_busy holds EXEC1 for five cycles
        threecycle = 1'b1; memread = 1'b0;
        step(); step();
        check("md_exec1", 32'(s0), 3);
        muldiv_busy = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("md_stall", 32'(st0), 1);
            check("md_noretire", 32'(r0), 0);
            step();
            check("md_hold", 32'(s0), 3);
        end
        check("md_cycles", cc0, 20);
        check("md_instrs", ic0, 3);
        muldiv_busy = 1'b0;
        #1;
        check("md_retire", 32'(r0), 1);
        step();
        check("md_instrs_after", ic0, 4);
        check("sat_cycles", 32'(cc2), 15);
        check("sat_instrs", 32'(ic2), 4);

        // Halt request on the retiring EXEC1 of instruction 5
        step(); step();
        check("h_exec1", 32'(s0), 3);
        halt_req = 1'b1;
        #1;
        check("h_retire", 32'(r0), 1);
        step();
        halt_req = 1'b0;
        check("h_delay_fetch", 32'(s0), 1);
        check("h_delay_active", 32'(a0), 1);
        check("h_now_halted", 32'(s1), 5);
        check("h_now_active", 32'(a1), 0);
        check("h_now_instrs", ic1, 5);
        step(); step();
        check("h_slot_exec1", 32'(s0), 3);
        check("h_slot_retire", 32'(r0), 1);
        step();
        check("h_halted", 32'(s0), 5);
        check("h_inactive", 32'(a0), 0);
        check("h_instrs", ic0, 6);
        check("h_cycles", cc0, 27);

        // Halted: counters frozen whatever the inputs do
        waitrequest = 1'b1; memread = 1'b1; memwrite = 1'b1; muldiv_busy = 1'b1; halt_req = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            check("frz_stall", 32'(st0), 0);
            check("frz_retire", 32'(r0), 0);
        end
        check("frz_state", 32'(s0), 5);
        check("frz_instrs", ic0, 6);
        check("frz_cycles", cc0, 27);
        check("frz_now_instrs", ic1, 5);
        check("frz_now_cycles", cc1, 24);
        waitrequest = 1'b0; memread = 1'b0; memwrite = 1'b0; muldiv_busy = 1'b0; halt_req = 1'b0;

        // Asynchronous reset between edges
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_state", 32'(s1), 0);
        check("arst_cycles", cc1, 0);
        check("arst_instrs", ic1, 0);
        check("arst_active", 32'(a0), 0);
        check("arst_state0", 32'(s0), 0);

        // Illegal state encoding leads to HALTED with sticky fault
        step();
        rst_n = 1'b1;
        step();
        check("ill_fetch", 32'(s0), 1);
        force u0.state_q = 3'd6;
        step();
        release u0.state_q;
        check("ill_fault", 32'(f0), 1);
        step();
        check("ill_halted", 32'(s0), 5);
        check("ill_inactive", 32'(a0), 0);
        step();
        check("ill_fault_sticky", 32'(f0), 1);
        check("ill_other_fault", 32'(f1), 0);
        rst_n = 1'b0;
        #1;
        check("ill_fault_clr", 32'(f0), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
